// File: rtl/uart_pkg.sv
// Shared types and frame builder for the UART transmit path.
// Frame layout is LSB first with the start bit at index 0.
package uart_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int FRAME_BITS = 11;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [7:0] d,
    input logic       eight,
    input logic       pen,
    input logic       ohel
  );
    logic                  p8;
    logic                  p7;
    logic [FRAME_BITS-1:0] f;
    p8 = (^d) ^ (ohel == ODD);
    p7 = (^d[6:0]) ^ (ohel == ODD);
    f  = '1;
    unique case (1'b1)
      eight && pen:   f = {1'b1, p8, d, 1'b0};
      eight && !pen:  f = {2'b11, d, 1'b0};
      !eight && pen:  f = {2'b11, p7, d[6:0], 1'b0};
      default:        f = {3'b111, d[6:0], 1'b0};
    endcase
    return f;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_baud_tick_gen.sv
// Bit-time pacing: counts clock cycles per bit slot and
// flags the last cycle of each slot.
module baud_tick_gen #(
  parameter int DIV_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] baud_k,
  input  logic             clr,
  input  logic             run,
  output logic             tick
);

  logic [DIV_W-1:0] baud_ctr;
  logic [DIV_W-1:0] last;

  // baud_k of 0 behaves as 1; >= keeps a shrunk divider from wrapping
  assign last = (baud_k == '0) ? '0 : baud_k - DIV_W'(1);
  assign tick = run && (baud_ctr >= last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_ctr <= '0;
    end else if (clr || tick) begin
      baud_ctr <= '0;
    end else if (run) begin
      baud_ctr <= baud_ctr + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames a byte, shifts it out
// LSB first and keeps the txrdy/busy/overrun flags.
module uart_tx_ctrl #(
  parameter int DIV_W      = 20,
  parameter int FRAME_BITS = uart_pkg::FRAME_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] baud_k,
  input  logic             eight,
  input  logic             pen,
  input  logic             ohel,
  input  logic             write,
  input  logic [7:0]       din,
  input  logic             clr_err,
  output logic             tx,
  output logic             txrdy,
  output logic             tx_busy,
  output logic             wr_err
);

  import uart_pkg::*;

  localparam int CW = $clog2(FRAME_BITS);

  state_t                state;
  state_t                state_nx;
  logic [FRAME_BITS-1:0] shreg;
  logic [CW-1:0]         bit_ctr;
  logic                  tick;
  logic                  accept;
  logic                  drop;
  logic                  shift;
  logic                  fin;

  baud_tick_gen #(
    .DIV_W (DIV_W)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .baud_k (baud_k),
    .clr    (accept),
    .run    (state == SHIFT),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = SHIFT;
      SHIFT:   if (fin) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    accept = write && txrdy;
    drop   = write && !txrdy;
    shift  = (state == SHIFT) && tick;
    fin    = shift && (bit_ctr == CW'(FRAME_BITS - 1));
  end

  // ones shifted in leave the line idle-high after the stop slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg   <= '1;
      bit_ctr <= '0;
    end else if (accept) begin
      shreg   <= build_frame(din, eight, pen, ohel);
      bit_ctr <= '0;
    end else if (shift) begin
      shreg   <= {1'b1, shreg[FRAME_BITS-1:1]};
      bit_ctr <= fin ? '0 : bit_ctr + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txrdy   <= 1'b1;
      tx_busy <= 1'b0;
    end else if (accept) begin
      txrdy   <= 1'b0;
      tx_busy <= 1'b1;
    end else if (fin) begin
      txrdy   <= 1'b1;
      tx_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_err <= 1'b0;
    end else if (drop) begin
      wr_err <= 1'b1;
    end else if (clr_err) begin
      wr_err <= 1'b0;
    end
  end

  assign tx = shreg[0];

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with hand-built
// expected frames checked cycle by cycle.
module tb_uart_tx_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [19:0] baud_k = 20'd4;
  logic        eight = 1'b0;
  logic        pen = 1'b0;
  logic        ohel = 1'b0;
  logic        write = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        clr_err = 1'b0;
  logic        tx;
  logic        txrdy;
  logic        tx_busy;
  logic        wr_err;

  int total = 0;
  int bad = 0;

  uart_tx_ctrl #(
    .DIV_W      (20),
    .FRAME_BITS (11)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .baud_k  (baud_k),
    .eight   (eight),
    .pen     (pen),
    .ohel    (ohel),
    .write   (write),
    .din     (din),
    .clr_err (clr_err),
    .tx      (tx),
    .txrdy   (txrdy),
    .tx_busy (tx_busy),
    .wr_err  (wr_err)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic send(
    input logic [7:0] d,
    input int         k,
    input logic       e,
    input logic       p,
    input logic       o
  );
    din    = d;
    baud_k = 20'(k);
    eight  = e;
    pen    = p;
    ohel   = o;
    write  = 1'b1;
    @(posedge clk);
    #1 write = 1'b0;
  endtask

  // starts just after the accept edge; k is the effective divider
  task automatic run_frame(
    input logic [10:0] exp,
    input int          k,
    input int          inj,
    input logic        inj_clr
  );
    for (int i = 0; i < 11 * k; i++) begin
      @(negedge clk);
      check($sformatf("tx c%0d", i), {31'd0, tx}, {31'd0, exp[i / k]});
      check($sformatf("txrdy c%0d", i), {31'd0, txrdy}, 32'd0);
      check($sformatf("busy c%0d", i), {31'd0, tx_busy}, 32'd1);
      if (i == inj) begin
        write   = 1'b1;
        din     = 8'hFF;
        clr_err = inj_clr;
      end else if (inj >= 0 && i == inj + 1) begin
        write   = 1'b0;
        clr_err = 1'b0;
        check("wr_err set", {31'd0, wr_err}, 32'd1);
      end
    end
    @(negedge clk);
    check("txrdy end", {31'd0, txrdy}, 32'd1);
    check("busy end", {31'd0, tx_busy}, 32'd0);
    check("tx end", {31'd0, tx}, 32'd1);
  endtask

  initial begin
    #12;
    check("rst tx", {31'd0, tx}, 32'd1);
    check("rst txrdy", {31'd0, txrdy}, 32'd1);
    check("rst busy", {31'd0, tx_busy}, 32'd0);
    check("rst wr_err", {31'd0, wr_err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 8-bit even parity, 4 cycles per slot
    send(8'hA5, 4, 1'b1, 1'b1, 1'b0);
    run_frame(11'b1_0_10100101_0, 4, -1, 1'b0);

    // 7-bit odd parity, bit 7 dropped
    send(8'hC1, 2, 1'b0, 1'b1, 1'b1);
    run_frame(11'b1_1_1_1000001_0, 2, -1, 1'b0);

    // divider 0 clamps to 1
    send(8'h00, 0, 1'b1, 1'b0, 1'b0);
    run_frame(11'b11_00000000_0, 1, -1, 1'b0);

    // overrun: dropped write sets wr_err, frame untouched
    check("wr_err pre", {31'd0, wr_err}, 32'd0);
    send(8'h81, 3, 1'b1, 1'b0, 1'b0);
    run_frame(11'b11_10000001_0, 3, 5, 1'b0);
    check("wr_err sticky", {31'd0, wr_err}, 32'd1);
    send(8'h81, 3, 1'b1, 1'b0, 1'b0);
    run_frame(11'b11_10000001_0, 3, 7, 1'b1);
    check("wr_err set prio", {31'd0, wr_err}, 32'd1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("wr_err clr", {31'd0, wr_err}, 32'd0);

    // back-to-back frames
    send(8'h55, 2, 1'b1, 1'b0, 1'b0);
    run_frame(11'b11_01010101_0, 2, -1, 1'b0);
    send(8'h0F, 2, 1'b1, 1'b0, 1'b0);
    run_frame(11'b11_00001111_0, 2, -1, 1'b0);

    // reset in slot 5, then a clean frame
    send(8'hA5, 3, 1'b1, 1'b1, 1'b0);
    repeat (16) @(negedge clk);
    check("slot5 tx", {31'd0, tx}, 32'd0);
    reset = 1'b0;
    #1;
    check("abort tx", {31'd0, tx}, 32'd1);
    check("abort txrdy", {31'd0, txrdy}, 32'd1);
    check("abort busy", {31'd0, tx_busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post rst tx", {31'd0, tx}, 32'd1);
    send(8'h3C, 3, 1'b1, 1'b1, 1'b0);
    run_frame(11'b1_0_00111100_0, 3, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
